uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter. It carries bytes in the FPGA→host direction of the USB<->UART link, which up to now is only a passthrough of the receive line.
- Accepts bytes from a local producer over a valid/ready handshake and queues them in a small FIFO.
- Serialises them onto uart_tx at a fixed baud rate derived from the board clock.
- Sits behind reset_sync/controlled_por_gen; its reset is their active-high output.

---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO fed by a valid/ready
// handshake, drained by a start/data/stop serialiser running at CLOCK_Fre/BAUD.
module uart_tx_fifo #(
  parameter int unsigned CLOCK_Fre  = 4000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned BIT_CYCLES = CLOCK_Fre / BAUD;
  localparam int unsigned BW = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam int unsigned PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLOCK_Fre/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push, pop, baud_end, fifo_nonempty;

  assign tx_ready      = (count_q != FULL_CNT);
  assign fifo_nonempty = (count_q != '0);
  assign push          = tx_valid & tx_ready;
  assign baud_end      = (baud_q == BAUD_LAST);
  assign uart_tx       = tx_q;
  assign busy          = (state_q != IDLE) | fifo_nonempty;

  // FIFO pointer and occupancy next-state; push and pop may coincide.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Serialiser next-state; the line value is computed one clock ahead so it can be registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // A queued byte starts its frame immediately, with no idle bit in between.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level model predicts the line,
// busy and tx_ready every cycle; directed scenarios add literal expectations.
module tb_uart_tx_fifo;

  localparam int unsigned BC    = 34;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * BC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'hAA;
  logic       tx_valid = 1'b1;
  logic       tx_ready, uart_tx, busy;
  logic [7:0] d2 = 8'h00;
  logic       v2 = 1'b0;
  logic       r2, line2, busy2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCK_Fre(4000000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy)
  );

  uart_tx_fifo #(.CLOCK_Fre(8), .BAUD(4), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .uart_tx(line2), .busy(busy2)
  );

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Frame-level model: a queue of waiting bytes plus the byte on the line and when its frame began.
  byte unsigned q[$];
  bit           act_m = 1'b0;
  int unsigned  start_m = 0;
  logic [7:0]   cur_m = 8'h00;
  bit           model_ok = 1'b0;
  int unsigned  edge_n = 0;
  bit           acc_m;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      q.delete();
      act_m    = 1'b0;
      model_ok = 1'b1;
    end else begin
      acc_m = tx_valid && (q.size() != DEPTH);
      if (act_m && (edge_n - start_m == FRAME)) act_m = 1'b0;
      if (!act_m && q.size() != 0) begin
        cur_m   = q.pop_front();
        act_m   = 1'b1;
        start_m = edge_n;
      end
      if (acc_m) q.push_back(tx_data);
    end
  end

  function automatic logic exp_line();
    int unsigned k;
    if (!act_m) return 1'b1;
    k = (edge_n - start_m) / BC;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_m[k-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("line", 32'(uart_tx), 32'(exp_line()));
      chk("busy", 32'(busy), 32'(act_m || (q.size() != 0)));
      chk("tx_ready", 32'(tx_ready), 32'(q.size() != DEPTH));
    end
  end

  task automatic wait_edge(input int unsigned e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Drive one byte so that it is sampled on edge e (the block must be ready).
  task automatic push_at(input int unsigned e, input logic [7:0] d);
    wait_edge(e - 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Decode a frame whose start bit begins on the line after edge s, sampling mid-bit.
  task automatic decode(input int unsigned s, input string nm, output logic [7:0] b);
    b = '0;
    wait_edge(s + BC / 2);
    chk({nm, "_start"}, 32'(uart_tx), 32'(1'b0));
    for (int unsigned k = 1; k <= 8; k++) begin
      wait_edge(s + k * BC + BC / 2);
      b[k-1] = uart_tx;
    end
    wait_edge(s + 9 * BC + BC / 2);
    chk({nm, "_stop"}, 32'(uart_tx), 32'(1'b1));
  endtask

  int unsigned acc_e [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n;
    int unsigned guard;
    logic [7:0]  b;
    logic [9:0]  exp2;

    // Reset with tx_valid held high: nothing may be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", 32'(uart_tx), 32'(1'b1));
    chk("rst_ready", 32'(tx_ready), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_accept", 32'(busy), 32'(1'b0));

    // Single byte 0x55.
    n = edge_n + 1;
    push_at(n, 8'h55);
    decode(n + 1, "single", b);
    chk("single_byte", 32'(b), 32'h55);
    wait_edge(n + 340);
    chk("single_busy_hi", 32'(busy), 32'(1'b1));
    wait_edge(n + 341);
    chk("single_busy_lo", 32'(busy), 32'(1'b0));
    repeat (5) @(negedge clk);

    // FIFO full: six bytes offered back to back.
    n = edge_n + 1;
    fork
      begin
        for (int unsigned i = 0; i < 6; i++) begin
          tx_data  = 8'(i + 1);
          tx_valid = 1'b1;
          guard    = 0;
          while (!tx_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 1000) chk("full_ready_timeout", 32'(tx_ready), 32'(1'b1));
          @(posedge clk);
          #1;
          acc_e[i] = edge_n;
        end
        tx_valid = 1'b0;
      end
      begin
        logic [7:0] fb;
        for (int unsigned k = 0; k < 6; k++) begin
          decode(n + 1 + k * FRAME, "full", fb);
          chk("full_order", 32'(fb), 32'(k + 1));
        end
      end
    join
    chk("full_acc1", acc_e[0], n);
    chk("full_acc5", acc_e[4], n + 4);
    chk("full_acc6", acc_e[5], n + 342);
    wait_edge(n + 2040);
    chk("full_busy_hi", 32'(busy), 32'(1'b1));
    wait_edge(n + 2041);
    chk("full_busy_lo", 32'(busy), 32'(1'b0));
    repeat (5) @(negedge clk);

    // Push exactly on the STOP-end pop edge with one byte queued.
    n = edge_n + 1;
    fork
      begin
        push_at(n, 8'h3C);
        push_at(n + 2, 8'hC3);
        push_at(n + 341, 8'h5A);
      end
      begin
        logic [7:0] pb;
        decode(n + 1, "pp_a", pb);
        chk("pp_a", 32'(pb), 32'h3C);
        decode(n + 341, "pp_b", pb);
        chk("pp_b", 32'(pb), 32'hC3);
        decode(n + 681, "pp_c", pb);
        chk("pp_c", 32'(pb), 32'h5A);
      end
    join
    wait_edge(n + 1020);
    chk("pp_busy_hi", 32'(busy), 32'(1'b1));
    wait_edge(n + 1021);
    chk("pp_busy_lo", 32'(busy), 32'(1'b0));
    repeat (5) @(negedge clk);

    // Reset during DATA bit 3 with two bytes queued.
    n = edge_n + 1;
    push_at(n, 8'h11);
    push_at(n + 1, 8'h22);
    push_at(n + 2, 8'h33);
    wait_edge(n + 150);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_line", 32'(uart_tx), 32'(1'b1));
    chk("midrst_busy", 32'(busy), 32'(1'b0));
    chk("midrst_ready", 32'(tx_ready), 32'(1'b1));
    reset = 1'b0;
    wait_edge(n + 551);
    chk("midrst_quiet_line", 32'(uart_tx), 32'(1'b1));
    chk("midrst_quiet_busy", 32'(busy), 32'(1'b0));

    // Minimum divider instance: 0xA3 framed as 0,1,1,0,0,0,1,0,1,1 at two clocks per bit.
    exp2 = 10'b1101000110;
    @(negedge clk);
    n = edge_n + 1;
    chk("min_ready", 32'(r2), 32'(1'b1));
    d2 = 8'hA3;
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    for (int unsigned j = 0; j < 20; j++) begin
      wait_edge(n + 1 + j);
      chk("min_line", 32'(line2), 32'(exp2[j/2]));
    end
    chk("min_busy_hi", 32'(busy2), 32'(1'b1));
    wait_edge(n + 21);
    chk("min_busy_lo", 32'(busy2), 32'(1'b0));
    chk("min_idle", 32'(line2), 32'(1'b1));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
